// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/status inputs and the
// per-state control lines, plus observability of state and retire count.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] OpCode;
  logic                MemReady;
  logic                Zero;
  logic                PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite;
  logic                MemtoReg, RegWrite, Reg2Loc, AluSrcA;
  logic [1:0]          AluSrcB;
  logic [1:0]          AluOp;
  logic                IllegalOp;
  logic [3:0]          State;
  logic [CNT_W-1:0]    InstrCount;

  // control unit side
  modport master (
    input  OpCode, MemReady, Zero,
    output PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegWrite, Reg2Loc, AluSrcA, AluSrcB, AluOp,
           IllegalOp, State, InstrCount
  );

  // datapath / instruction register side
  modport slave (
    output OpCode, MemReady, Zero,
    input  PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegWrite, Reg2Loc, AluSrcA, AluSrcB, AluOp,
           IllegalOp, State, InstrCount
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with memory wait handshake, illegal-opcode trap and a
// retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_W = 11,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_MEM = 4'd3,
    MEM_RD = 4'd4, MEM_WR = 4'd5, WB_R = 4'd6, WB_MEM = 4'd7,
    BRANCH = 4'd8, ILLEGAL = 4'd9
  } state_t;

  typedef struct packed {
    logic       pcWrite, pcSrc, iorD, irWrite, memRead, memWrite;
    logic       memtoReg, regWrite, reg2Loc, aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       illegalOp;
  } ctrl_t;

  state_t      state, nextState;
  logic [10:0] opReg;
  logic [10:0] liveOp;
  ctrl_t       ctrl;
  logic        retire;

  assign liveOp = bus.OpCode[OPCODE_W-1 -: 11];

  function automatic logic isR(input logic [10:0] op);
    return op[10] && (op[7:4] == 4'b0101) && (op[2:0] == 3'b000);
  endfunction
  function automatic logic isLdur(input logic [10:0] op);
    return op == 11'b11111000010;
  endfunction
  function automatic logic isStur(input logic [10:0] op);
    return op == 11'b11111000000;
  endfunction
  function automatic logic isCbz(input logic [10:0] op);
    return op[10:3] == 8'b10110100;
  endfunction
  function automatic logic isB(input logic [10:0] op);
    return op[10:5] == 6'b000101;
  endfunction

  // state register; opcode is latched on the DECODE exit edge so later
  // states are immune to the instruction register changing underneath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      opReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opReg <= liveOp;
    end
  end

  // next-state: only DECODE looks at the live opcode
  always_comb begin
    nextState = FETCH;
    case (state)
      FETCH:    nextState = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        if (isR(liveOp))                         nextState = EXEC_R;
        else if (isLdur(liveOp) || isStur(liveOp)) nextState = EXEC_MEM;
        else if (isCbz(liveOp) || isB(liveOp))     nextState = BRANCH;
        else                                     nextState = ILLEGAL;
      end
      EXEC_R:   nextState = WB_R;
      EXEC_MEM: nextState = isStur(opReg) ? MEM_WR : MEM_RD;
      MEM_RD:   nextState = bus.MemReady ? WB_MEM : MEM_RD;
      MEM_WR:   nextState = bus.MemReady ? FETCH : MEM_WR;
      default:  nextState = FETCH;  // WB_R, WB_MEM, BRANCH, ILLEGAL, 10..15
    endcase
  end

  // Moore outputs; everything forced low while reset is held
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = 2'b01;
        ctrl.irWrite = bus.MemReady;
        ctrl.pcWrite = bus.MemReady;
      end
      DECODE: begin
        ctrl.aluSrcB = 2'b11;
        ctrl.reg2Loc = isStur(liveOp) || isCbz(liveOp);
      end
      EXEC_R: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = 2'b10;
      end
      EXEC_MEM: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
        ctrl.reg2Loc = isStur(opReg);
      end
      MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEM_WR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
        ctrl.reg2Loc  = 1'b1;
      end
      WB_R:   ctrl.regWrite = 1'b1;
      WB_MEM: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = 2'b01;
        ctrl.reg2Loc = 1'b1;
        ctrl.pcSrc   = 1'b1;
        ctrl.pcWrite = isB(opReg) || bus.Zero;
      end
      ILLEGAL: ctrl.illegalOp = 1'b1;
      default: ctrl = '0;
    endcase
    if (!rst_n) ctrl = '0;
  end

  // an instruction retires on the edge leaving its last state
  assign retire = (state == WB_R) || (state == WB_MEM) || (state == BRANCH) ||
                  ((state == MEM_WR) && bus.MemReady);

  // retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bus.InstrCount <= '0;
    else if (retire) bus.InstrCount <= bus.InstrCount + 1'b1;
  end

  assign bus.PCWrite   = ctrl.pcWrite;
  assign bus.PCSrc     = ctrl.pcSrc;
  assign bus.IorD      = ctrl.iorD;
  assign bus.IRWrite   = ctrl.irWrite;
  assign bus.MemRead   = ctrl.memRead;
  assign bus.MemWrite  = ctrl.memWrite;
  assign bus.MemtoReg  = ctrl.memtoReg;
  assign bus.RegWrite  = ctrl.regWrite;
  assign bus.Reg2Loc   = ctrl.reg2Loc;
  assign bus.AluSrcA   = ctrl.aluSrcA;
  assign bus.AluSrcB   = ctrl.aluSrcB;
  assign bus.AluOp     = ctrl.aluOp;
  assign bus.IllegalOp = ctrl.illegalOp;
  assign bus.State     = state;
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle LEGv8 control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath control lines from the current state. It is the sequenced successor of the single-cycle opcode decoder. It adds unconditional branch `B`, a variable-latency memory handshake, an illegal-opcode trap and a retired-instruction counter. It sits between the instruction register / memory interface and the shared ALU, register file and PC datapath.

## Interface
- OPCODE_W, 11, opcode input width; must be ≥ 11; decode uses OpCode[OPCODE_W-1 -: 11], lower bits ignored
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- OpCode  in  OPCODE_W  instruction opcode field from the instruction register
- MemReady  in  1  memory completes the current access this cycle
- Zero  in  1  ALU zero flag
- PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, Reg2Loc, AluSrcA  out  1 each  datapath controls
- AluSrcB  out  2  ALU B select: 00 register, 01 constant 4, 10 sign-extended offset, 11 shifted branch offset
- AluOp  out  2  00 add, 01 pass B / compare-zero, 10 funct-decoded
- IllegalOp  out  1  one-cycle pulse in ILLEGAL
- State  out  4  current state encoding
- InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Opcode classes on the top 11 bits (x = don't care):
  - R: 1xx0101x000
  - LDUR: 11111000010
  - STUR: 11111000000
  - CBZ: 10110100xxx
  - B: 000101xxxxx
  - any other value is illegal.
- States and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_MEM=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_MEM=7, BRANCH=8, ILLEGAL=9. Codes 10–15 are unreachable; if entered, the next state is FETCH.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=00. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=00. Reg2Loc=1 for live STUR/CBZ.
  - The live OpCode is captured into an internal opcode register on the DECODE exit edge; every later state decodes only from that register.
  - Next state by class: R→EXEC_R, LDUR/STUR→EXEC_MEM, CBZ/B→BRANCH, illegal→ILLEGAL.
- EXEC_R: AluSrcA=1, AluSrcB=00, AluOp=10; next state WB_R.
- EXEC_MEM: AluSrcA=1, AluSrcB=10, AluOp=00, Reg2Loc=1 for STUR; next state MEM_RD (LDUR) or MEM_WR (STUR).
- MEM_RD: MemRead=1, IorD=1; held until MemReady, then WB_MEM.
- MEM_WR: MemWrite=1, IorD=1, Reg2Loc=1; held until MemReady, then FETCH.
- WB_R: RegWrite=1, MemtoReg=0; next state FETCH.
- WB_MEM: RegWrite=1, MemtoReg=1; next state FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=01, Reg2Loc=1, PCSrc=1. PCWrite=1 for B; PCWrite=Zero for CBZ. Next state FETCH.
- ILLEGAL: IllegalOp=1, no writes; next state FETCH. The instruction is not counted.
- Any output not listed for a state is 0.
- InstrCount increments by 1, modulo 2^CNT_W, on each exit edge from WB_R, WB_MEM, BRANCH, and from MEM_WR with MemReady=1.

## Timing
- Outputs are decoded from the registered state and the opcode register only. Zero and MemReady enter combinationally only where stated above (PCWrite, IRWrite).
- Minimum cycles per instruction, at MemReady=1:
  - R: 4
  - LDUR: 5
  - STUR: 4
  - CBZ/B: 3
  - illegal: 3
- Each memory-wait cycle adds 1 to these counts.
- rst_n low forces State=FETCH, opcode register=0 and InstrCount=0 immediately. All outputs are 0 while rst_n is low; in particular MemRead is forced 0 despite FETCH.
- The first cycle after rst_n rises presents the FETCH outputs.
- Reset asserted mid-instruction abandons it with no count and no write. Partial memory waits are dropped.
- A change on OpCode after the DECODE exit edge has no effect on the instruction in flight.
- InstrCount wrap: from 2^CNT_W−1 the next retire gives 0.

## Test plan
- Reset release, MemReady=1, R opcode 10001011000: State 0→1→2→6→0; RegWrite=1 only in state 6; InstrCount=1 after 4 cycles.
- LDUR 11111000010 with MemReady low for 2 cycles in MEM_RD: MemRead and IorD held for 3 cycles in state 4; WB_MEM has MemtoReg=1 and RegWrite=1; 7 cycles total.
- CBZ 10110100101 with Zero=1, then again with Zero=0: PCWrite=1, PCSrc=1 in BRANCH for the first; PCWrite=0 for the second; InstrCount +2.
- Illegal opcode 00000000000: DECODE→ILLEGAL; IllegalOp pulses exactly 1 cycle; InstrCount unchanged; returns to FETCH.
- STUR, with OpCode changed to R in EXEC_MEM and rst_n pulsed low during the MEM_WR wait: MemWrite stays asserted (latched opcode wins); on reset all outputs go 0 at once, State=0, InstrCount=0.
- CNT_W=2, five B instructions (00010100000): InstrCount 1,2,3,0,1.
